// File: rtl/pie_command_encoder.sv
// PIE transmit encoder: emits delimiter, data-0, RTcal, optional TRcal and the
// command bits as a tick-rate carrier envelope (1 = carrier on, 0 = modulated low).
module pie_command_encoder #(
    parameter int TARI_TICKS  = 4,
    parameter int DATA1_TICKS = 7,
    parameter int PW_TICKS    = 2,
    parameter int DELIM_TICKS = 3,
    parameter int TRCAL_TICKS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic start,
    input  logic preamble_sel,
    input  logic in_dat,
    input  logic in_last,
    input  logic in_vld,
    output logic in_rdy,
    output logic out_dat,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int RTCAL_TICKS = TARI_TICKS + DATA1_TICKS;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_TICKS = max2(max2(max2(TARI_TICKS, DATA1_TICKS),
                                         max2(DELIM_TICKS, TRCAL_TICKS)), RTCAL_TICKS);
    localparam int CNT_WIDTH = $clog2(MAX_TICKS + 1);

    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef enum logic [2:0] {IDLE, DELIM, DATA0, RTCAL, TRCAL, DATA, END_S} state_t;

    state_t state, state_d;
    cnt_t   cnt, cnt_d, seg_len;
    logic   out_d, busy_d, done_d, err_d;
    logic   pre, pre_d, bit_val, bit_d, bit_last, last_d, fail, fail_d;
    logic   cnt_end, fetch_pos;

    // Length of the segment currently being emitted; IDLE/END never count.
    always_comb begin
        unique case (state)
            DELIM:   seg_len = cnt_t'(DELIM_TICKS);
            DATA0:   seg_len = cnt_t'(TARI_TICKS);
            RTCAL:   seg_len = cnt_t'(RTCAL_TICKS);
            TRCAL:   seg_len = cnt_t'(TRCAL_TICKS);
            DATA:    seg_len = bit_val ? cnt_t'(DATA1_TICKS) : cnt_t'(TARI_TICKS);
            default: seg_len = cnt_t'(1);
        endcase
    end

    assign cnt_end   = (cnt == seg_len - cnt_t'(1));
    assign fetch_pos = (state == RTCAL && !pre) || (state == TRCAL) ||
                       (state == DATA && !bit_last);
    assign in_rdy    = tick && cnt_end && fetch_pos;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state;
        cnt_d   = cnt;
        out_d   = out_dat;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pre_d   = pre;
        bit_d   = bit_val;
        last_d  = bit_last;
        fail_d  = fail;

        if (state == IDLE) begin
            if (start) begin
                state_d = DELIM;
                cnt_d   = '0;
                busy_d  = 1'b1;
                pre_d   = preamble_sel;
                fail_d  = 1'b0;
            end
        end else if (tick) begin
            if (state == END_S) begin
                // Closing tick restores the carrier, so the last low lasts exactly PW_TICKS.
                out_d   = 1'b1;
                busy_d  = 1'b0;
                done_d  = !fail;
                err_d   = fail;
                state_d = IDLE;
            end else begin
                out_d = (state != DELIM) && (cnt < seg_len - cnt_t'(PW_TICKS));
                if (!cnt_end) begin
                    cnt_d = cnt + cnt_t'(1);
                end else begin
                    cnt_d = '0;
                    if (fetch_pos) begin
                        if (in_vld) begin
                            bit_d   = in_dat;
                            last_d  = in_last;
                            state_d = DATA;
                        end else begin
                            fail_d  = 1'b1;
                            state_d = END_S;
                        end
                    end else begin
                        unique case (state)
                            DELIM:   state_d = DATA0;
                            DATA0:   state_d = RTCAL;
                            RTCAL:   state_d = TRCAL;
                            default: state_d = END_S;
                        endcase
                    end
                end
            end
        end
    end

    // NOTE: registers use non-blocking assignment so all of them update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            out_dat  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            pre      <= 1'b0;
            bit_val  <= 1'b0;
            bit_last <= 1'b0;
            fail     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            out_dat  <= out_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            pre      <= pre_d;
            bit_val  <= bit_d;
            bit_last <= last_d;
            fail     <= fail_d;
        end
    end

endmodule

// File: tb/tb_pie_command_encoder.sv
// Self-checking bench for pie_command_encoder: captured envelope samples are compared
// with a sequence built from the PIE symbol rules.
module tb_pie_command_encoder;

    localparam int TARI  = 4;
    localparam int D1    = 7;
    localparam int PW    = 2;
    localparam int DELIM = 3;
    localparam int TRCAL = 16;
    localparam int RTCAL = TARI + D1;

    logic clk, rst, tick, start, preamble_sel, in_dat, in_last, in_vld;
    logic in_rdy, out_dat, busy, done, err;

    int checks = 0;
    int errors = 0;
    int tick_div = 1;
    int tick_n = 0;
    bit cap_en = 0;
    bit pend = 0;
    bit stop = 0;
    logic prev_out = 1'b1;
    bit cap_q[$];
    bit exp_q[$];
    int done_n, err_n, rdy_n, hold_viol, busy_low;

    pie_command_encoder dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .preamble_sel(preamble_sel),
        .in_dat(in_dat), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_dat(out_dat), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tick_div: N>0 = every Nth clock, 0 = random with 3/4 density
    always @(posedge clk) begin
        #1;
        tick_n++;
        tick = (tick_div == 0) ? ($urandom_range(0, 3) != 0) : ((tick_n % tick_div) == 0);
    end

    // Capture one sample per tick taken while busy; out_dat must not move otherwise.
    always @(negedge clk) begin
        if (pend) cap_q.push_back(out_dat);
        else if (cap_en && out_dat !== prev_out) hold_viol++;
        prev_out = out_dat;
        pend = cap_en && tick && busy;
        if (done) done_n++;
        if (err) err_n++;
        if (in_rdy) rdy_n++;
    end

    task automatic push_sym(input int len);
        for (int k = 0; k < len; k++) exp_q.push_back(k < len - PW);
    endtask

    task automatic build_exp(input bit pre, input bit bits[$], input bit lasts[$]);
        int i = 0;
        exp_q.delete();
        do begin
            repeat (DELIM) exp_q.push_back(1'b0);
            push_sym(TARI);
            push_sym(RTCAL);
            if (pre) push_sym(TRCAL);
            if (bits.size() == 0) begin
                exp_q.push_back(1'b1);
                return;
            end
            do begin
                push_sym(bits[i] ? D1 : TARI);
                i++;
            end while (!lasts[i-1] && i < bits.size());
            exp_q.push_back(1'b1);
        end while (i < bits.size());
    endtask

    task automatic feed(input bit bits[$], input bit lasts[$], input int max_gap);
        foreach (bits[i]) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            if (stop) break;
            in_vld = 1'b1;
            in_dat = bits[i];
            in_last = lasts[i];
            do @(negedge clk); while (!in_rdy && !stop);
            @(posedge clk);
            #1;
            in_vld = 1'b0;
            if (stop) break;
        end
    endtask

    task automatic wait_end(input string name, input int n_end);
        int dn = 0;
        int cyc = 0;
        while (dn < n_end) begin
            @(negedge clk);
            if (done || err) dn++;
            else if (!busy) busy_low++;
            cyc++;
            if (cyc > 4000) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: end pulses got %0d expected %0d", name, dn, n_end);
                break;
            end
        end
        start = 1'b0;
        stop = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_cmd(input string name, input bit pre, input bit bits[$], input bit lasts[$],
                           input int max_gap, input bit hold_start, input int mid_pulse);
        int n_end = 0;
        int idx = -1;
        bit under;
        under = (bits.size() == 0);
        foreach (lasts[i]) if (lasts[i]) n_end++;
        if (under) n_end = 1;
        build_exp(pre, bits, lasts);
        cap_q.delete();
        done_n = 0; err_n = 0; rdy_n = 0; hold_viol = 0; busy_low = 0; stop = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        preamble_sel = pre;
        cap_en = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        fork
            feed(bits, lasts, max_gap);
            wait_end(name, n_end);
            if (mid_pulse > 0) begin
                repeat (mid_pulse) @(posedge clk);
                #1;
                start = 1'b1;
                preamble_sel = !pre;
                @(posedge clk);
                #1;
                start = 1'b0;
                preamble_sel = pre;
            end
        join
        cap_en = 1'b0;
        in_vld = 1'b0;

        checks++;
        if (cap_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s sample_count: got %0d expected %0d", name, cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (cap_q[i] !== exp_q[i]) begin
                idx = i;
                break;
            end
        checks++;
        if (idx >= 0) begin
            errors++;
            $display("FAIL %s samples: index %0d got %0b expected %0b", name, idx, cap_q[idx], exp_q[idx]);
        end
        checks++;
        if (done_n !== (under ? 0 : n_end)) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected %0d", name, done_n, under ? 0 : n_end);
        end
        checks++;
        if (err_n !== (under ? 1 : 0)) begin
            errors++;
            $display("FAIL %s err_pulses: got %0d expected %0d", name, err_n, under ? 1 : 0);
        end
        checks++;
        if (rdy_n !== bits.size() + (under ? 1 : 0)) begin
            errors++;
            $display("FAIL %s in_rdy_fires: got %0d expected %0d", name, rdy_n, bits.size() + (under ? 1 : 0));
        end
        checks++;
        if (busy_low !== 0) begin
            errors++;
            $display("FAIL %s busy_gaps: got %0d expected 0", name, busy_low);
        end
        checks++;
        if (hold_viol !== 0) begin
            errors++;
            $display("FAIL %s out_change_without_tick: got %0d expected 0", name, hold_viol);
        end
        checks++;
        if (busy !== 1'b0 || out_dat !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_after: busy=%b out_dat=%b expected busy=0 out_dat=1", name, busy, out_dat);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_dat !== 1'b1) begin errors++; $display("FAIL reset out_dat: got %b expected 1", out_dat); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++;
        if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset in_rdy: got %b expected 0", in_rdy); end
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset pulses: done=%b err=%b expected 0 0", done, err);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_frame_sync;
        bit b[$], l[$];
        tick_div = 1;
        b.push_back(1'b1); l.push_back(1'b0);
        b.push_back(1'b0); l.push_back(1'b1);
        run_cmd("frame_sync_10", 1'b0, b, l, 0, 1'b0, 0);
    endtask

    task automatic test_preamble;
        bit b[$], l[$];
        tick_div = 1;
        b.push_back(1'b0); l.push_back(1'b1);
        run_cmd("preamble_0", 1'b1, b, l, 0, 1'b0, 0);
    endtask

    task automatic test_slow_tick;
        bit b[$], l[$];
        tick_div = 3;
        b.push_back(1'b1); l.push_back(1'b0);
        b.push_back(1'b0); l.push_back(1'b1);
        run_cmd("slow_tick", 1'b0, b, l, 2, 1'b0, 0);
        tick_div = 1;
    endtask

    task automatic test_underrun;
        bit b[$], l[$];
        tick_div = 1;
        run_cmd("underrun_fs", 1'b0, b, l, 0, 1'b0, 0);
        run_cmd("underrun_pre", 1'b1, b, l, 0, 1'b0, 0);
    endtask

    task automatic test_start_ignored;
        bit b[$], l[$];
        tick_div = 1;
        for (int i = 0; i < 8; i++) begin
            b.push_back(1'($urandom_range(0, 1)));
            l.push_back(i == 7);
        end
        run_cmd("start_ignored", 1'b1, b, l, 1, 1'b0, 15);
    endtask

    task automatic test_reset_mid;
        bit found = 0;
        tick_div = 1;
        cap_q.delete();
        cap_en = 1'b1;
        in_vld = 1'b1; in_dat = 1'b1; in_last = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        preamble_sel = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cap_q.size() >= 20 && out_dat === 1'b0 && busy === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reset_mid reach_data: got 0 expected 1"); end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_dat !== 1'b1) begin errors++; $display("FAIL reset_mid out_dat: got %b expected 1", out_dat); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        checks++;
        if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_mid in_rdy: got %b expected 0", in_rdy); end
        in_vld = 1'b0;
        cap_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_dat !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid idle_after: busy=%b out_dat=%b expected 0 1", busy, out_dat);
        end
    endtask

    task automatic test_random;
        bit b[$], l[$];
        for (int r = 0; r < 3; r++) begin
            b.delete();
            l.delete();
            for (int i = 0; i < 64; i++) begin
                b.push_back(1'($urandom_range(0, 1)));
                l.push_back(i == 63);
            end
            tick_div = (r == 1) ? 0 : 1;
            run_cmd($sformatf("random_%0d", r), 1'($urandom_range(0, 1)), b, l, 2, 1'b0, 0);
        end
        tick_div = 1;
    endtask

    task automatic test_back_to_back;
        bit b[$], l[$];
        tick_div = 1;
        for (int i = 0; i < 10; i++) begin
            b.push_back(1'($urandom_range(0, 1)));
            l.push_back(i == 4 || i == 9);
        end
        run_cmd("back_to_back", 1'($urandom_range(0, 1)), b, l, 1, 1'b1, 0);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; start = 1'b0; preamble_sel = 1'b0;
        in_dat = 1'b0; in_last = 1'b0; in_vld = 1'b0;
        test_reset();
        test_frame_sync();
        test_preamble();
        test_slow_tick();
        test_underrun();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
